// File: rtl/cpu_datapath_if.sv
// Control and observation bundle between an external controller and the
// single-cycle datapath: controller-driven controls out, internal nodes back.
interface cpu_datapath_if #(
   parameter int WORDSIZE = 64
);
   logic [4:0]          cpu_rf_addr_a;
   logic [4:0]          cpu_rf_addr_b;
   logic [4:0]          cpu_rf_write_addr;
   logic                cpu_rf_write_en;
   logic [WORDSIZE-1:0] cpu_immediate;
   logic                cpu_mux_0_sel;
   logic                cpu_mux_1_sel;
   logic                cpu_mux_2_sel;
   logic [2:0]          cpu_alu_operation;
   logic                cpu_dm_write_en;

   logic [WORDSIZE-1:0] cpu_reading_rf_data_a;
   logic [WORDSIZE-1:0] cpu_reading_rf_data_b;
   logic [WORDSIZE-1:0] cpu_reading_alu_result;
   logic [WORDSIZE-1:0] cpu_reading_dm_data_output;
   logic [WORDSIZE-1:0] cpu_reading_mux_0_out;
   logic [WORDSIZE-1:0] cpu_reading_mux_1_out;
   logic [WORDSIZE-1:0] cpu_reading_mux_2_out;

   modport master (
      output cpu_rf_addr_a, cpu_rf_addr_b, cpu_rf_write_addr, cpu_rf_write_en,
             cpu_immediate, cpu_mux_0_sel, cpu_mux_1_sel, cpu_mux_2_sel,
             cpu_alu_operation, cpu_dm_write_en,
      input  cpu_reading_rf_data_a, cpu_reading_rf_data_b, cpu_reading_alu_result,
             cpu_reading_dm_data_output, cpu_reading_mux_0_out,
             cpu_reading_mux_1_out, cpu_reading_mux_2_out
   );

   modport slave (
      input  cpu_rf_addr_a, cpu_rf_addr_b, cpu_rf_write_addr, cpu_rf_write_en,
             cpu_immediate, cpu_mux_0_sel, cpu_mux_1_sel, cpu_mux_2_sel,
             cpu_alu_operation, cpu_dm_write_en,
      output cpu_reading_rf_data_a, cpu_reading_rf_data_b, cpu_reading_alu_result,
             cpu_reading_dm_data_output, cpu_reading_mux_0_out,
             cpu_reading_mux_1_out, cpu_reading_mux_2_out
   );
endinterface

// File: rtl/cpu_datapath.sv
// Single-cycle 64-bit RISC-V-style datapath without a control unit: register
// file, ALU, data memory and three muxes, all steered directly from the bus.
module cpu_datapath #(
   parameter int WORDSIZE = 64
) (
   input logic           cpu_clk,
   input logic           cpu_rst_n,
   cpu_datapath_if.slave bus
);
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

   logic [WORDSIZE-1:0] rf [32];
   logic [WORDSIZE-1:0] dm [256];

   logic [WORDSIZE-1:0] rf_data_a;
   logic [WORDSIZE-1:0] rf_data_b;
   logic [WORDSIZE-1:0] mux_0_out;
   logic [WORDSIZE-1:0] mux_1_out;
   logic [WORDSIZE-1:0] mux_2_out;
   logic [WORDSIZE-1:0] alu_result;
   logic [WORDSIZE-1:0] dm_data_output;
   logic [7:0]          dm_addr;
   logic [5:0]          shamt;
   alu_op_e             alu_op;

   // x0 is hardwired to zero on the read side; its storage is never written.
   assign rf_data_a = (bus.cpu_rf_addr_a == 5'd0) ? '0 : rf[bus.cpu_rf_addr_a];
   assign rf_data_b = (bus.cpu_rf_addr_b == 5'd0) ? '0 : rf[bus.cpu_rf_addr_b];

   assign mux_0_out = bus.cpu_mux_0_sel ? rf_data_b : rf_data_a;
   assign mux_1_out = bus.cpu_mux_1_sel ? rf_data_b : bus.cpu_immediate;

   assign alu_op = alu_op_e'(bus.cpu_alu_operation);
   assign shamt  = mux_1_out[5:0];

   // NOTE: every variable gets a default before the case so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      alu_result = '0;
      unique case (alu_op)
         ALU_ADD: alu_result = mux_0_out + mux_1_out;
         ALU_SUB: alu_result = mux_0_out - mux_1_out;
         ALU_AND: alu_result = mux_0_out & mux_1_out;
         ALU_OR:  alu_result = mux_0_out | mux_1_out;
         ALU_XOR: alu_result = mux_0_out ^ mux_1_out;
         ALU_SLL: alu_result = mux_0_out << shamt;
         ALU_SRL: alu_result = mux_0_out >> shamt;
         ALU_SLT: alu_result = {{(WORDSIZE-1){1'b0}},
                                ($signed(mux_0_out) < $signed(mux_1_out))};
         default: alu_result = '0;
      endcase
   end

   // Doubleword-indexed memory; upper address bits are dropped so it wraps.
   assign dm_addr        = alu_result[7:0];
   assign dm_data_output = dm[dm_addr];

   assign mux_2_out = bus.cpu_mux_2_sel ? dm_data_output : alu_result;

   // NOTE: state is updated with non-blocking assignments so every read in
   // this cycle (including a load using its own base register) sees pre-edge values.
   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (bus.cpu_rf_write_en && (bus.cpu_rf_write_addr != 5'd0)) begin
         rf[bus.cpu_rf_write_addr] <= mux_2_out;
      end
   end

   // NOTE: the memory is cleared by reset, which rules out mapping it onto
   // a RAM macro; this is a deliberate trade for a deterministic power-up state.
   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         for (int i = 0; i < 256; i++) dm[i] <= '0;
      end else if (bus.cpu_dm_write_en) begin
         dm[dm_addr] <= rf_data_a;
      end
   end

   assign bus.cpu_reading_rf_data_a      = rf_data_a;
   assign bus.cpu_reading_rf_data_b      = rf_data_b;
   assign bus.cpu_reading_alu_result     = alu_result;
   assign bus.cpu_reading_dm_data_output = dm_data_output;
   assign bus.cpu_reading_mux_0_out      = mux_0_out;
   assign bus.cpu_reading_mux_1_out      = mux_1_out;
   assign bus.cpu_reading_mux_2_out      = mux_2_out;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: hand-computed vectors checked with
// immediate assertions after each control setup and each clock edge.
module tb_cpu_datapath;
   localparam int W = 64;

   logic cpu_clk = 1'b0;
   logic cpu_rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   cpu_datapath_if #(.WORDSIZE(W)) bus ();

   cpu_datapath #(.WORDSIZE(W)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst_n (cpu_rst_n),
      .bus       (bus)
   );

   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic idle();
      bus.cpu_rf_addr_a     = '0;
      bus.cpu_rf_addr_b     = '0;
      bus.cpu_rf_write_addr = '0;
      bus.cpu_rf_write_en   = 1'b0;
      bus.cpu_immediate     = '0;
      bus.cpu_mux_0_sel     = 1'b0;
      bus.cpu_mux_1_sel     = 1'b0;
      bus.cpu_mux_2_sel     = 1'b0;
      bus.cpu_alu_operation = 3'b000;
      bus.cpu_dm_write_en   = 1'b0;
   endtask

   // A=rf_a(addr_a) through mux0=0, B=immediate through mux1=0.
   task automatic alu_imm(input string tag, input logic [4:0] ra, input logic [2:0] op,
                          input logic [W-1:0] imm, input logic [W-1:0] exp);
      idle();
      bus.cpu_rf_addr_a     = ra;
      bus.cpu_alu_operation = op;
      bus.cpu_immediate     = imm;
      #1;
      check(tag, bus.cpu_reading_alu_result, exp);
   endtask

   initial begin
      idle();
      cpu_rst_n = 1'b0;
      tick();
      cpu_rst_n = 1'b1;
      #1;

      // Reset state: all-zero controls give zero on every observation output.
      check("rst_rf_a",  bus.cpu_reading_rf_data_a,      64'd0);
      check("rst_rf_b",  bus.cpu_reading_rf_data_b,      64'd0);
      check("rst_alu",   bus.cpu_reading_alu_result,     64'd0);
      check("rst_dm",    bus.cpu_reading_dm_data_output, 64'd0);
      check("rst_mux0",  bus.cpu_reading_mux_0_out,      64'd0);
      check("rst_mux1",  bus.cpu_reading_mux_1_out,      64'd0);
      check("rst_mux2",  bus.cpu_reading_mux_2_out,      64'd0);
      for (int r = 0; r < 32; r++) begin
         bus.cpu_rf_addr_a = 5'(r);
         #1;
         check($sformatf("rst_x%0d", r), bus.cpu_reading_rf_data_a, 64'd0);
      end
      idle();
      bus.cpu_immediate = 64'd28;
      #1;
      check("rst_dm28", bus.cpu_reading_dm_data_output, 64'd0);

      // addi x2, x7, 5
      idle();
      bus.cpu_rf_addr_a     = 5'd7;
      bus.cpu_rf_addr_b     = 5'd2;
      bus.cpu_immediate     = 64'd5;
      bus.cpu_rf_write_addr = 5'd2;
      bus.cpu_rf_write_en   = 1'b1;
      #1;
      check("addi_alu",    bus.cpu_reading_alu_result, 64'd5);
      check("addi_x2_pre", bus.cpu_reading_rf_data_b,  64'd0);
      tick();
      check("addi_x2", bus.cpu_reading_rf_data_b, 64'd5);

      // sd x2, 23(x2) -> mem[28] = 5
      idle();
      bus.cpu_rf_addr_a   = 5'd2;
      bus.cpu_rf_addr_b   = 5'd2;
      bus.cpu_mux_0_sel   = 1'b1;
      bus.cpu_immediate   = 64'd23;
      bus.cpu_dm_write_en = 1'b1;
      #1;
      check("st_alu",    bus.cpu_reading_alu_result,     64'd28);
      check("st_dm_pre", bus.cpu_reading_dm_data_output, 64'd0);
      tick();
      check("st_dm",     bus.cpu_reading_dm_data_output, 64'd5);
      check("st_x2_kept", bus.cpu_reading_rf_data_a,     64'd5);
      bus.cpu_dm_write_en = 1'b0;

      // add x1, x2, x0
      idle();
      bus.cpu_rf_addr_a     = 5'd2;
      bus.cpu_rf_addr_b     = 5'd0;
      bus.cpu_mux_1_sel     = 1'b1;
      bus.cpu_rf_write_addr = 5'd1;
      bus.cpu_rf_write_en   = 1'b1;
      tick();
      idle();
      bus.cpu_rf_addr_a = 5'd1;
      #1;
      check("add_x1", bus.cpu_reading_rf_data_a, 64'd5);

      // sub x1, x0, x2
      idle();
      bus.cpu_rf_addr_a     = 5'd0;
      bus.cpu_rf_addr_b     = 5'd2;
      bus.cpu_mux_1_sel     = 1'b1;
      bus.cpu_alu_operation = 3'b001;
      bus.cpu_rf_write_addr = 5'd1;
      bus.cpu_rf_write_en   = 1'b1;
      tick();
      idle();
      bus.cpu_rf_addr_a = 5'd1;
      #1;
      check("sub_x1", bus.cpu_reading_rf_data_a, 64'hFFFF_FFFF_FFFF_FFFB);

      // ld x3, 23(x2)
      idle();
      bus.cpu_rf_addr_a     = 5'd2;
      bus.cpu_immediate     = 64'd23;
      bus.cpu_mux_2_sel     = 1'b1;
      bus.cpu_rf_write_addr = 5'd3;
      bus.cpu_rf_write_en   = 1'b1;
      #1;
      check("ld_mux2", bus.cpu_reading_mux_2_out, 64'd5);
      tick();
      idle();
      bus.cpu_rf_addr_b = 5'd3;
      #1;
      check("ld_x3", bus.cpu_reading_rf_data_b, 64'd5);

      // Write to x0 is discarded.
      idle();
      bus.cpu_immediate     = 64'h1234;
      bus.cpu_rf_write_addr = 5'd0;
      bus.cpu_rf_write_en   = 1'b1;
      #1;
      check("x0_mux2_pre", bus.cpu_reading_mux_2_out, 64'h1234);
      tick();
      idle();
      #1;
      check("x0_a", bus.cpu_reading_rf_data_a, 64'd0);
      check("x0_b", bus.cpu_reading_rf_data_b, 64'd0);

      // ALU ops with x3=5 and x1=-5 as operand A.
      alu_imm("alu_and",  5'd3, 3'b010, 64'd3,    64'd1);
      alu_imm("alu_or",   5'd3, 3'b011, 64'd3,    64'd7);
      alu_imm("alu_xor",  5'd3, 3'b100, 64'd3,    64'd6);
      alu_imm("alu_sll",  5'd3, 3'b101, 64'h44,   64'h50);
      alu_imm("alu_srl",  5'd1, 3'b110, 64'd4,    64'h0FFF_FFFF_FFFF_FFFF);
      alu_imm("alu_slt1", 5'd1, 3'b111, 64'd3,    64'd1);
      alu_imm("alu_slt0", 5'd3, 3'b111, 64'd3,    64'd0);
      alu_imm("alu_ovf",  5'd1, 3'b000, 64'd10,   64'd5);

      // sd x1, 0(x2) -> mem[5] = -5
      idle();
      bus.cpu_rf_addr_a   = 5'd1;
      bus.cpu_rf_addr_b   = 5'd2;
      bus.cpu_mux_0_sel   = 1'b1;
      bus.cpu_dm_write_en = 1'b1;
      tick();

      // ld x2, 0(x2): address comes from the pre-edge base (5).
      idle();
      bus.cpu_rf_addr_a     = 5'd2;
      bus.cpu_mux_2_sel     = 1'b1;
      bus.cpu_rf_write_addr = 5'd2;
      bus.cpu_rf_write_en   = 1'b1;
      tick();
      idle();
      bus.cpu_rf_addr_a = 5'd2;
      #1;
      check("ld_own_base", bus.cpu_reading_rf_data_a, 64'hFFFF_FFFF_FFFF_FFFB);

      // ld x5, 0x11C(x0): address wraps to 28.
      idle();
      bus.cpu_immediate     = 64'h11C;
      bus.cpu_mux_2_sel     = 1'b1;
      bus.cpu_rf_write_addr = 5'd5;
      bus.cpu_rf_write_en   = 1'b1;
      #1;
      check("wrap_dm", bus.cpu_reading_dm_data_output, 64'd5);
      tick();
      idle();
      bus.cpu_rf_addr_b = 5'd5;
      #1;
      check("wrap_x5", bus.cpu_reading_rf_data_b, 64'd5);

      // Same-cycle read of written index: old value until the edge.
      idle();
      bus.cpu_rf_addr_a     = 5'd4;
      bus.cpu_immediate     = 64'd9;
      bus.cpu_rf_write_addr = 5'd4;
      bus.cpu_rf_write_en   = 1'b1;
      #1;
      check("raw_pre", bus.cpu_reading_rf_data_a, 64'd0);
      tick();
      check("raw_post", bus.cpu_reading_rf_data_a, 64'd9);

      // Mid-sequence reset with writes requested: everything clears.
      idle();
      bus.cpu_rf_addr_a     = 5'd3;
      bus.cpu_immediate     = 64'd28;
      bus.cpu_rf_write_addr = 5'd6;
      bus.cpu_rf_write_en   = 1'b1;
      bus.cpu_dm_write_en   = 1'b1;
      cpu_rst_n = 1'b0;
      tick();
      cpu_rst_n = 1'b1;
      idle();
      for (int r = 1; r <= 6; r++) begin
         bus.cpu_rf_addr_a = 5'(r);
         #1;
         check($sformatf("rst2_x%0d", r), bus.cpu_reading_rf_data_a, 64'd0);
      end
      idle();
      bus.cpu_immediate = 64'd28;
      #1;
      check("rst2_dm28", bus.cpu_reading_dm_data_output, 64'd0);
      bus.cpu_immediate = 64'd5;
      #1;
      check("rst2_dm5", bus.cpu_reading_dm_data_output, 64'd0);
      bus.cpu_immediate = 64'd33;
      #1;
      check("rst2_dm33", bus.cpu_reading_dm_data_output, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
